// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: op codes and a width helper shared by the register bank and its ALU.
package reg_bank_pkg;
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_BSF   = 3'b010;
  localparam logic [2:0] OP_BCF   = 3'b011;
  localparam logic [2:0] OP_INC   = 3'b100;
  localparam logic [2:0] OP_DEC   = 3'b101;
  localparam logic [2:0] OP_CLR   = 3'b110;
  localparam logic [2:0] OP_RSV   = 3'b111;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/reg_bank_alu.sv
// reg_bank_alu: combinational next value and flag candidates for one addressed register.
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]              i_op,
  input  logic [WIDTH-1:0]        i_old,
  input  logic [clog2(WIDTH)-1:0] i_bit_sel,
  input  logic [WIDTH-1:0]        i_data,
  output logic [WIDTH-1:0]        o_new,
  output logic                    o_zero,
  output logic                    o_carry,
  output logic                    o_illegal
);
  localparam int BW = clog2(WIDTH);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_mask;
  logic             w_bit_bad;
  assign w_sum     = {1'b0, i_old} + (WIDTH+1)'(1);
  assign w_dif     = {1'b0, i_old} - (WIDTH+1)'(1);
  assign w_mask    = WIDTH'(1) << i_bit_sel;
  assign w_bit_bad = {1'b0, i_bit_sel} >= (BW+1)'(WIDTH);
  always_comb begin
    o_new     = i_old;
    o_illegal = 1'b0;
    case (i_op)
      OP_WRITE: o_new = i_data;
      OP_BSF: begin
        o_new     = i_old | w_mask;
        o_illegal = w_bit_bad;
      end
      OP_BCF: begin
        o_new     = i_old & ~w_mask;
        o_illegal = w_bit_bad;
      end
      OP_INC:  o_new = w_sum[WIDTH-1:0];
      OP_DEC:  o_new = w_dif[WIDTH-1:0];
      OP_CLR:  o_new = '0;
      OP_RSV:  o_illegal = 1'b1;
      default: o_new = i_old;
    endcase
  end
  assign o_zero  = o_new == '0;
  // the extra top bit of the WIDTH+1 result is the INC carry-out or the DEC borrow
  assign o_carry = (i_op == OP_DEC) ? w_dif[WIDTH] : w_sum[WIDTH];
endmodule

// File: rtl/reg_bank_rst.sv
// reg_bank_rst: register bank with one op per clock, two combinational reads, Z/C/err flags.
// Optional shadow save/restore bank enabled by REG_BANK_SHADOW_EN.
module reg_bank_rst
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NUM_REGS    = 4,
  parameter int               ADDR_W      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic                    clock,
  input  logic                    reset,
`ifdef REG_BANK_SHADOW_EN
  input  logic                    save,
  input  logic                    restore,
`endif
  input  logic [2:0]              op,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [clog2(WIDTH)-1:0] bit_sel,
  input  logic [WIDTH-1:0]        data_in,
  input  logic [ADDR_W-1:0]       rd_addr_a,
  input  logic [ADDR_W-1:0]       rd_addr_b,
  output logic [WIDTH-1:0]        rd_data_a,
  output logic [WIDTH-1:0]        rd_data_b,
  output logic                    zero,
  output logic                    carry,
  output logic                    err
);
  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);
  logic [WIDTH-1:0] r_regs [NUM_REGS];
`ifdef REG_BANK_SHADOW_EN
  logic [WIDTH-1:0] r_sh_regs [NUM_REGS];
  logic             r_sh_zero;
  logic             r_sh_carry;
`endif
  logic             w_addr_ok;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_new;
  logic             w_zero;
  logic             w_carry;
  logic             w_illegal;
  logic             w_bad;
  logic             w_wr;
  logic             w_zen;
  logic             w_cen;
  assign rd_data_a = ({1'b0, rd_addr_a} < NR) ? r_regs[rd_addr_a] : '0;
  assign rd_data_b = ({1'b0, rd_addr_b} < NR) ? r_regs[rd_addr_b] : '0;
  assign w_addr_ok = {1'b0, addr} < NR;
  assign w_old     = w_addr_ok ? r_regs[addr] : '0;
  // NOP targets no register, so an out-of-range address with NOP is not an error
  assign w_bad     = w_illegal || (!w_addr_ok && op != OP_NOP);
  assign w_wr      = !w_bad && w_addr_ok && op != OP_NOP;
  assign w_zen     = op inside {OP_WRITE, OP_INC, OP_DEC, OP_CLR};
  assign w_cen     = op inside {OP_INC, OP_DEC};
  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .i_op     (op),
    .i_old    (w_old),
    .i_bit_sel(bit_sel),
    .i_data   (data_in),
    .o_new    (w_new),
    .o_zero   (w_zero),
    .o_carry  (w_carry),
    .o_illegal(w_illegal)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
      zero  <= 1'b0;
      carry <= 1'b0;
      err   <= 1'b0;
`ifdef REG_BANK_SHADOW_EN
      for (int i = 0; i < NUM_REGS; i++) r_sh_regs[i] <= RESET_VALUE;
      r_sh_zero  <= 1'b0;
      r_sh_carry <= 1'b0;
    end else if (restore) begin
      r_regs <= r_sh_regs;
      zero   <= r_sh_zero;
      carry  <= r_sh_carry;
      err    <= 1'b0;
`endif
    end else begin
      err <= w_bad;
      if (w_wr) r_regs[addr] <= w_new;
      if (w_wr && w_zen) zero <= w_zero;
      if (w_wr && w_cen) carry <= w_carry;
`ifdef REG_BANK_SHADOW_EN
      if (save) begin
        r_sh_regs  <= r_regs;
        r_sh_zero  <= zero;
        r_sh_carry <= carry;
      end
`endif
    end
  end
endmodule

// File: tb/tb_reg_bank_rst.sv
// tb_reg_bank_rst: directed plan plus random ops checked against an integer reference model.
module tb_reg_bank_rst;
  import reg_bank_pkg::*;
  logic       clock = 1'b0;
  logic       reset, save, restore, reset3;
  logic [2:0] op, bit_sel, op3, b3;
  logic [1:0] addr, rd_addr_a, rd_addr_b, addr3, rda3, rdb3;
  logic [7:0] data_in, rd_data_a, rd_data_b, d3, rd3a, rd3b;
  logic       zero, carry, err, z3, c3, e3;
  int         n_chk = 0, n_pass = 0;
  int         m_r[4], m_sr[4];
  int         m_z, m_c, m_e, m_sz, m_sc;
  always #5 clock = ~clock;
  reg_bank_rst u_dut (
    .clock(clock), .reset(reset),
`ifdef REG_BANK_SHADOW_EN
    .save(save), .restore(restore),
`endif
    .op(op), .addr(addr), .bit_sel(bit_sel), .data_in(data_in),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .zero(zero), .carry(carry), .err(err)
  );
  reg_bank_rst #(.NUM_REGS(3)) u_dut3 (
    .clock(clock), .reset(reset3),
`ifdef REG_BANK_SHADOW_EN
    .save(1'b0), .restore(1'b0),
`endif
    .op(op3), .addr(addr3), .bit_sel(b3), .data_in(d3),
    .rd_addr_a(rda3), .rd_addr_b(rdb3),
    .rd_data_a(rd3a), .rd_data_b(rd3b),
    .zero(z3), .carry(c3), .err(e3)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_step(input int o, a, b, d, rn, s, r);
    int  old;
    bit  bad;
    if (rn == 0) begin
      foreach (m_r[i]) begin m_r[i] = 255; m_sr[i] = 255; end
      m_z = 0; m_c = 0; m_e = 0; m_sz = 0; m_sc = 0;
    end else if (r != 0) begin
      m_r = m_sr; m_z = m_sz; m_c = m_sc; m_e = 0;
    end else begin
      old = m_r[a];
      bad = (o == 7) || ((o == 2 || o == 3) && b >= 8);
      if (s != 0) begin m_sr = m_r; m_sz = m_z; m_sc = m_c; end
      m_e = bad;
      if (!bad)
        case (o)
          1: begin m_r[a] = d; m_z = (d == 0); end
          2: m_r[a] = old | (1 << b);
          3: m_r[a] = old & ~(1 << b) & 255;
          4: begin m_r[a] = (old + 1) % 256; m_z = (m_r[a] == 0); m_c = (old == 255); end
          5: begin m_r[a] = (old + 255) % 256; m_z = (m_r[a] == 0); m_c = (old == 0); end
          6: begin m_r[a] = 0; m_z = 1; end
          default: ;
        endcase
    end
  endtask
  task automatic do_op(input int o, a, b, d, rn, s, r);
    @(negedge clock);
    op = 3'(o); addr = 2'(a); bit_sel = 3'(b); data_in = 8'(d);
    reset = rn[0]; save = s[0]; restore = r[0];
    rd_addr_a = 2'(a); rd_addr_b = 2'($urandom_range(0, 3));
    #1;
    chk("rd_same_cycle", rd_data_a, m_r[a]);
    chk("rdb_same_cycle", rd_data_b, m_r[rd_addr_b]);
    @(posedge clock);
    model_step(o, a, b, d, rn, s, r);
    #1;
    chk("rd_after", rd_data_a, m_r[a]);
    chk("zero", zero, m_z);
    chk("carry", carry, m_c);
    chk("err", err, m_e);
  endtask
  task automatic run(input int o, a, b, d);
    do_op(o, a, b, d, 1, 0, 0);
  endtask
  initial begin
    reset = 0; reset3 = 0; save = 0; restore = 0;
    op = OP_INC; addr = 0; bit_sel = 0; data_in = 0; rd_addr_a = 0; rd_addr_b = 0;
    op3 = OP_INC; addr3 = 0; b3 = 0; d3 = 0; rda3 = 0; rdb3 = 0;
    repeat (2) @(posedge clock);
    model_step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset3 = 1; op3 = OP_WRITE; addr3 = 3; d3 = 8'h55; rda3 = 3; rdb3 = 0;
    @(posedge clock); #1;
    chk("u3_addr_err", e3, 1);
    chk("u3_rd_oob", rd3a, 0);
    chk("u3_r0_kept", rd3b, 8'hFF);
    chk("u3_zero_held", z3, 0);
    @(negedge clock);
    op3 = OP_WRITE; addr3 = 2; d3 = 8'h00; rda3 = 2;
    @(posedge clock); #1;
    chk("u3_err_clear", e3, 0);
    chk("u3_write", rd3a, 0);
    chk("u3_zero", z3, 1);
    @(negedge clock);
    op3 = OP_NOP;
    reset = 1; op = OP_NOP;
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i); #1;
      chk("rst_reg", rd_data_a, 8'hFF);
    end
    chk("rst_zero", zero, 0); chk("rst_carry", carry, 0); chk("rst_err", err, 0);
    run(OP_WRITE, 2, 0, 8'h00); chk("wr0_zero", zero, 1);
    run(OP_INC, 2, 0, 0);  chk("inc_val", rd_data_a, 8'h01); chk("inc_z", zero, 0); chk("inc_c", carry, 0);
    run(OP_DEC, 2, 0, 0);  chk("dec_val", rd_data_a, 8'h00); chk("dec_z", zero, 1); chk("dec_c", carry, 0);
    run(OP_DEC, 2, 0, 0);  chk("dec_wrap", rd_data_a, 8'hFF); chk("dec_wz", zero, 0); chk("dec_wc", carry, 1);
    run(OP_INC, 0, 0, 0);  chk("inc_wrap", rd_data_a, 8'h00); chk("inc_wz", zero, 1); chk("inc_wc", carry, 1);
    run(OP_BSF, 0, 7, 0);  chk("bsf_val", rd_data_a, 8'h80); chk("bsf_z", zero, 1); chk("bsf_c", carry, 1);
    run(OP_WRITE, 1, 0, 8'hA5); chk("wr_a5", rd_data_a, 8'hA5);
    run(OP_BCF, 1, 0, 0);  chk("bcf_val", rd_data_a, 8'hA4);
    run(OP_WRITE, 3, 0, 8'h10);
    run(OP_RSV, 3, 0, 0);  chk("rsv_val", rd_data_a, 8'h10); chk("rsv_err", err, 1); chk("rsv_z", zero, 0);
    run(OP_NOP, 3, 0, 0);  chk("rsv_err_drop", err, 0);
    do_op(OP_INC, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_val", rd_data_a, 8'hFF); chk("rst_mid_z", zero, 0); chk("rst_mid_c", carry, 0);
`ifdef REG_BANK_SHADOW_EN
    run(OP_WRITE, 1, 0, 8'h3C);
    do_op(OP_NOP, 1, 0, 0, 1, 1, 0);
    run(OP_WRITE, 1, 0, 8'h00);
    run(OP_DEC, 2, 0, 0);
    do_op(OP_INC, 1, 0, 0, 1, 0, 1);
    chk("restore_val", rd_data_a, 8'h3C); chk("restore_z", zero, 0);
    chk("restore_c", carry, 0); chk("restore_err", err, 0);
`endif
    repeat (400) begin
      int s, r;
      s = 0; r = 0;
`ifdef REG_BANK_SHADOW_EN
      s = ($urandom_range(0, 7) == 0) ? 1 : 0;
      r = ($urandom_range(0, 11) == 0) ? 1 : 0;
`endif
      do_op($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255),
            ($urandom_range(0, 40) == 0) ? 0 : 1, s, r);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
